// File: rtl/rv32i_types.sv
// Shared RV32I core types: reorder-buffer entry layout and default ROB sizing.
package rv32i_types;

  localparam int ROB_DEPTH  = 32;
  localparam int ROB_NUM_WB = 4;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic        is_br;
    logic        mispred;
    logic [4:0]  rd_addr;
    logic        regf_we;
    logic [31:0] pc;
    logic [31:0] pc_new;
    logic [31:0] data;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_n.sv
// In-order-commit reorder buffer with NUM_WB out-of-order writeback ports and
// mispredict flush raised combinationally from the committing head entry.
module reorder_buffer_n
  import rv32i_types::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int NUM_WB = ROB_NUM_WB,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc_valid,
  output logic                    alloc_ready,
  input  logic [4:0]              alloc_rd_addr,
  input  logic                    alloc_regf_we,
  input  logic [31:0]             alloc_pc,
  input  logic                    alloc_is_br,
  output logic [IDX_W-1:0]        alloc_idx,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*IDX_W-1:0] wb_idx,
  input  logic [NUM_WB*32-1:0]    wb_data,
  input  logic [NUM_WB-1:0]       wb_mispred,
  input  logic [NUM_WB*32-1:0]    wb_pc_new,
  output logic                    commit_valid,
  output logic [IDX_W-1:0]        commit_idx,
  output logic [4:0]              commit_rd_addr,
  output logic                    commit_regf_we,
  output logic [31:0]             commit_data,
  output logic [31:0]             commit_pc,
  output logic                    flush,
  output logic [31:0]             flush_pc,
  output logic [IDX_W:0]          count
);

  logic [IDX_W:0]   head_reg, tail_reg;
  logic [IDX_W-1:0] head_idx, tail_idx;
  rob_entry_t       entries [DEPTH];
  rob_entry_t       head_entry;
  logic             full, empty, alloc_fire, commit_fire;

  assign head_idx   = head_reg[IDX_W-1:0];
  assign tail_idx   = tail_reg[IDX_W-1:0];
  assign full       = (head_idx == tail_idx) && (head_reg[IDX_W] != tail_reg[IDX_W]);
  assign empty      = (head_reg == tail_reg);
  assign head_entry = entries[head_idx];

  assign commit_fire = !empty && head_entry.valid && head_entry.done;
  assign flush       = commit_fire && head_entry.is_br && head_entry.mispred;
  assign alloc_ready = !full && !flush;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_idx   = tail_idx;
  assign count       = tail_reg - head_reg;

  // Commit fields are forced to zero whenever nothing is committing.
  assign commit_valid   = commit_fire;
  assign commit_idx     = commit_fire ? head_idx : '0;
  assign commit_rd_addr = commit_fire ? head_entry.rd_addr : '0;
  assign commit_regf_we = commit_fire && head_entry.regf_we;
  assign commit_data    = commit_fire ? head_entry.data : '0;
  assign commit_pc      = commit_fire ? head_entry.pc : '0;
  assign flush_pc       = flush ? head_entry.pc_new : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      head_reg <= head_reg + {{IDX_W{1'b0}}, commit_fire};
      tail_reg <= tail_reg + {{IDX_W{1'b0}}, alloc_fire};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [IDX_W-1:0] ENTRY_IDX = IDX_W'(gi);
      rob_entry_t  entry_reg;
      logic        wb_hit;
      logic        wb_mis_sel;
      logic [31:0] wb_data_sel, wb_pc_sel;

      assign entries[gi] = entry_reg;

      // Scan high to low so the lowest-numbered matching port wins.
      always_comb begin
        wb_hit      = 1'b0;
        wb_mis_sel  = 1'b0;
        wb_data_sel = '0;
        wb_pc_sel   = '0;
        for (int p = NUM_WB - 1; p >= 0; p--) begin
          if (wb_valid[p] && (wb_idx[p*IDX_W +: IDX_W] == ENTRY_IDX)) begin
            wb_hit      = 1'b1;
            wb_mis_sel  = wb_mispred[p];
            wb_data_sel = wb_data[p*32 +: 32];
            wb_pc_sel   = wb_pc_new[p*32 +: 32];
          end
        end
      end

      // Commit and allocate never target the same slot: that needs a full ROB.
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          entry_reg <= '0;
        end else if (commit_fire && (head_idx == ENTRY_IDX)) begin
          entry_reg <= '0;
        end else if (alloc_fire && (tail_idx == ENTRY_IDX)) begin
          entry_reg <= '{valid: 1'b1, done: 1'b0, is_br: alloc_is_br, mispred: 1'b0,
                         rd_addr: alloc_rd_addr, regf_we: alloc_regf_we,
                         pc: alloc_pc, pc_new: 32'h0, data: 32'h0};
        end else if (wb_hit && entry_reg.valid) begin
          entry_reg.done    <= 1'b1;
          entry_reg.data    <= wb_data_sel;
          entry_reg.mispred <= wb_mis_sel;
          entry_reg.pc_new  <= wb_pc_sel;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_reorder_buffer_n.sv
// Randomised scoreboard bench for reorder_buffer_n: a queue-of-entries model in
// allocation order predicts every commit, flush, count and handshake value.
module tb_reorder_buffer_n;

  localparam int DEPTH  = 32;
  localparam int NUM_WB = 4;
  localparam int IDX_W  = 5;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    alloc_valid, alloc_ready;
  logic [4:0]              alloc_rd_addr;
  logic                    alloc_regf_we;
  logic [31:0]             alloc_pc;
  logic                    alloc_is_br;
  logic [IDX_W-1:0]        alloc_idx;
  logic [NUM_WB-1:0]       wb_valid;
  logic [NUM_WB*IDX_W-1:0] wb_idx;
  logic [NUM_WB*32-1:0]    wb_data;
  logic [NUM_WB-1:0]       wb_mispred;
  logic [NUM_WB*32-1:0]    wb_pc_new;
  logic                    commit_valid;
  logic [IDX_W-1:0]        commit_idx;
  logic [4:0]              commit_rd_addr;
  logic                    commit_regf_we;
  logic [31:0]             commit_data, commit_pc;
  logic                    flush;
  logic [31:0]             flush_pc;
  logic [IDX_W:0]          count;

  reorder_buffer_n #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_rd_addr(alloc_rd_addr), .alloc_regf_we(alloc_regf_we),
    .alloc_pc(alloc_pc), .alloc_is_br(alloc_is_br), .alloc_idx(alloc_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
    .wb_mispred(wb_mispred), .wb_pc_new(wb_pc_new),
    .commit_valid(commit_valid), .commit_idx(commit_idx),
    .commit_rd_addr(commit_rd_addr), .commit_regf_we(commit_regf_we),
    .commit_data(commit_data), .commit_pc(commit_pc),
    .flush(flush), .flush_pc(flush_pc), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [4:0]  rd;
    bit          we;
    logic [31:0] pc;
    bit          br;
    bit          done;
    logic [31:0] data;
    bit          mis;
    logic [31:0] pcn;
  } rob_model_t;

  rob_model_t model_q[$];
  int  tail_m    = 0;
  bit  ready_now = 1'b1;
  bit  mon_en    = 1'b0;
  int  compared  = 0;
  int  mismatched = 0;

  bit          st_v   [NUM_WB];
  int          st_idx [NUM_WB];
  logic [31:0] st_data[NUM_WB];
  bit          st_mis [NUM_WB];
  logic [31:0] st_pcn [NUM_WB];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic stage_wb(input int p, input int idx, input logic [31:0] d,
                          input bit mis, input logic [31:0] pcn);
    st_v[p] = 1'b1; st_idx[p] = idx; st_data[p] = d; st_mis[p] = mis; st_pcn[p] = pcn;
  endtask

  // One cycle of stimulus: drives inputs just after the monitor's sample point
  // and applies their architectural effect to the model.
  task automatic step(input bit av, input logic [4:0] rd, input bit br, input logic [31:0] pc);
    @(negedge clk); #1;
    rst = 1'b0;
    for (int p = NUM_WB - 1; p >= 0; p--) begin
      wb_valid[p]              = st_v[p];
      wb_idx[p*IDX_W +: IDX_W] = IDX_W'(st_idx[p]);
      wb_data[p*32 +: 32]      = st_data[p];
      wb_mispred[p]            = st_mis[p];
      wb_pc_new[p*32 +: 32]    = st_pcn[p];
      if (st_v[p])
        foreach (model_q[k])
          if (model_q[k].idx == st_idx[p]) begin
            model_q[k].done = 1'b1;
            model_q[k].data = st_data[p];
            model_q[k].mis  = st_mis[p];
            model_q[k].pcn  = st_pcn[p];
          end
      st_v[p] = 1'b0;
    end
    alloc_valid   = av;
    alloc_rd_addr = rd;
    alloc_regf_we = (rd != 5'd0);
    alloc_pc      = pc;
    alloc_is_br   = br;
    if (av && ready_now) begin
      model_q.push_back('{idx: tail_m, rd: rd, we: (rd != 5'd0), pc: pc, br: br,
                          done: 1'b0, data: 32'h0, mis: 1'b0, pcn: 32'h0});
      tail_m = (tail_m + 1) % DEPTH;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    alloc_valid = 1'b0;
    wb_valid = '0;
    model_q.delete();
    tail_m = 0;
  endtask

  // Monitor: compares every DUT output against the model, then retires the head.
  bit exp_cv, exp_fl;
  always @(negedge clk) begin
    if (mon_en) begin
      exp_cv = (model_q.size() > 0) && model_q[0].done;
      exp_fl = exp_cv && model_q[0].br && model_q[0].mis;
      chk("commit_valid", commit_valid, exp_cv);
      chk("flush", flush, exp_fl);
      chk("count", count, model_q.size());
      chk("alloc_ready", alloc_ready, (model_q.size() < DEPTH) && !exp_fl);
      chk("alloc_idx", alloc_idx, tail_m);
      ready_now = (model_q.size() < DEPTH) && !exp_fl;
      if (model_q.size() == 0) begin
        chk("idle_commit_data", commit_data, 0);
        chk("idle_commit_pc", commit_pc, 0);
      end
      if (exp_cv) begin
        if (commit_valid) begin
          $display("commit idx=%0d rd=%0d we=%0b data=0x%08h pc=0x%08h flush=%0b",
                   commit_idx, commit_rd_addr, commit_regf_we, commit_data, commit_pc, flush);
          chk("commit_idx", commit_idx, model_q[0].idx);
          chk("commit_rd", commit_rd_addr, model_q[0].rd);
          chk("commit_we", commit_regf_we, model_q[0].we);
          chk("commit_data", commit_data, model_q[0].data);
          chk("commit_pc", commit_pc, model_q[0].pc);
          if (exp_fl) chk("flush_pc", flush_pc, model_q[0].pcn);
        end
        if (exp_fl) begin
          model_q.delete();
          tail_m = 0;
        end else begin
          void'(model_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    alloc_valid = 1'b0; alloc_rd_addr = '0; alloc_regf_we = 1'b0;
    alloc_pc = '0; alloc_is_br = 1'b0;
    wb_valid = '0; wb_idx = '0; wb_data = '0; wb_mispred = '0; wb_pc_new = '0;
    for (int p = 0; p < NUM_WB; p++) st_v[p] = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Three allocations, then out-of-order completion.
    step(1'b1, 5'd1, 1'b0, 32'h1000_0000);
    step(1'b1, 5'd2, 1'b0, 32'h1000_0004);
    step(1'b1, 5'd3, 1'b0, 32'h1000_0008);
    stage_wb(0, 2, 32'h33, 1'b0, 32'h0); step(1'b0, 5'd0, 1'b0, 32'h0);
    stage_wb(1, 0, 32'h11, 1'b0, 32'h0); step(1'b0, 5'd0, 1'b0, 32'h0);
    stage_wb(2, 1, 32'h22, 1'b0, 32'h0); step(1'b0, 5'd0, 1'b0, 32'h0);
    idle(4);

    // Fill to capacity, try to overfill, then free one slot and wrap.
    for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 5'(i + 4), 1'b0, 32'h2000_0000 + 32'(i * 4));
    stage_wb(0, model_q[0].idx, 32'hC0DE, 1'b0, 32'h0);
    step(1'b1, 5'd9, 1'b0, 32'h2100_0000);
    step(1'b1, 5'd10, 1'b0, 32'h2100_0004);
    step(1'b1, 5'd11, 1'b0, 32'h2100_0008);
    for (int c = 0; c < 12; c++) begin
      for (int p = 0; p < NUM_WB && p < model_q.size(); p++)
        stage_wb(p, model_q[p].idx, 32'h5000 + 32'(c * 4 + p), 1'b0, 32'h0);
      step(1'b0, 5'd0, 1'b0, 32'h0);
    end
    idle(3);

    // Ports 0 and 3 collide on index 5.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 5'(i + 1), 1'b0, 32'h3000_0000 + 32'(i * 4));
    stage_wb(0, 5, 32'hAA, 1'b0, 32'h0);
    stage_wb(3, 5, 32'hBB, 1'b0, 32'h0);
    step(1'b0, 5'd0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      stage_wb(1, i, 32'h100 + 32'(i), 1'b0, 32'h0);
      step(1'b0, 5'd0, 1'b0, 32'h0);
    end
    idle(8);

    // Mispredicted branch at head with four younger entries.
    do_reset();
    step(1'b1, 5'd1, 1'b1, 32'h6000_0000);
    for (int i = 0; i < 4; i++) step(1'b1, 5'(i + 2), 1'b0, 32'h6000_0004 + 32'(i * 4));
    stage_wb(1, 2, 32'h77, 1'b0, 32'h0);
    stage_wb(2, 0, 32'h0, 1'b1, 32'h6000_0100);
    step(1'b0, 5'd0, 1'b0, 32'h0);
    idle(3);

    // Reset with ten entries, three of them done.
    for (int i = 0; i < 10; i++) step(1'b1, 5'(i + 1), 1'b0, 32'h7000_0000 + 32'(i * 4));
    stage_wb(0, 5, 32'h55, 1'b0, 32'h0);
    stage_wb(1, 6, 32'h66, 1'b0, 32'h0);
    stage_wb(2, 7, 32'h77, 1'b0, 32'h0);
    step(1'b0, 5'd0, 1'b0, 32'h0);
    do_reset();
    idle(3);

    // Randomised traffic, including branches that sometimes mispredict.
    for (int c = 0; c < 2000; c++) begin
      for (int p = 0; p < NUM_WB; p++)
        if ($urandom_range(0, 2) == 0) begin
          int tgt;
          if (model_q.size() > 0 && $urandom_range(0, 3) != 0)
            tgt = model_q[$urandom_range(0, model_q.size() - 1)].idx;
          else
            tgt = $urandom_range(0, DEPTH - 1);
          stage_wb(p, tgt, $urandom, ($urandom_range(0, 7) == 0), $urandom);
        end
      step($urandom_range(0, 2) != 0, 5'($urandom), ($urandom_range(0, 3) == 0), $urandom);
    end

    // Drain whatever remains.
    for (int c = 0; c < 40; c++) begin
      for (int p = 0; p < NUM_WB && p < model_q.size(); p++)
        stage_wb(p, model_q[p].idx, 32'hD000 + 32'(c), 1'b0, 32'h0);
      step(1'b0, 5'd0, 1'b0, 32'h0);
    end
    idle(3);
    chk("drained_count", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
